// File: rtl/i2c_req_arbiter_if.sv
// Signal bundle linking N_REQ client blocks and one shared I2C driver to the arbiter.
// Ports: slave = arbiter view (req_*/drv_rdata/drv_busy in; grant/done/err/rdata/drv_* out);
//        master = client + driver view (mirror of slave).
interface i2c_req_arbiter_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   req_rw;
    logic [7*N_REQ-1:0] req_addr;
    logic [8*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   done;
    logic [N_REQ-1:0]   err;
    logic [7:0]         rdata;
    logic               drv_start;
    logic               drv_rw;
    logic [6:0]         drv_addr;
    logic [7:0]         drv_wdata;
    logic               drv_abort;
    logic [7:0]         drv_rdata;
    logic               drv_busy;

    modport slave (
        input  req, req_rw, req_addr, req_wdata, drv_rdata, drv_busy,
        output grant, done, err, rdata,
        output drv_start, drv_rw, drv_addr, drv_wdata, drv_abort
    );

    modport master (
        output req, req_rw, req_addr, req_wdata, drv_rdata, drv_busy,
        input  grant, done, err, rdata,
        input  drv_start, drv_rw, drv_addr, drv_wdata, drv_abort
    );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C driver between N_REQ clients, with launch/transfer timeouts.
// Ports: clk, rst_n (async active-low), bus (i2c_req_arbiter_if.slave: client requests + driver link).
module i2c_req_arbiter #(
    parameter int N_REQ      = 4,
    parameter int LAUNCH_TMO = 1024,
    parameter int XFER_TMO   = 65535,
    parameter int CNT_W      = 16
) (
    input logic              clk,
    input logic              rst_n,
    i2c_req_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] LAUNCH_LAST = CNT_W'(LAUNCH_TMO - 1);
    localparam logic [CNT_W-1:0] XFER_LAST   = CNT_W'(XFER_TMO - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        COMPLETE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               start;
    logic               found;
    logic [PTR_W-1:0]   idx;
    logic [PTR_W-1:0]   pick;
    logic [PTR_W-1:0]   rr;
    logic [PTR_W-1:0]   owner;
    logic [CNT_W-1:0]   cnt;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   done_q;
    logic [N_REQ-1:0]   err_q;
    logic [7:0]         rdata_q;
    logic               rw_q;
    logic [6:0]         addr_q;
    logic [7:0]         wdata_q;
    logic               abort_q;

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.drv_start = start;
    assign bus.drv_rw    = rw_q;
    assign bus.drv_addr  = addr_q;
    assign bus.drv_wdata = wdata_q;
    assign bus.drv_abort = abort_q;

    // First requester at or above the rr pointer, wrapping around.
    always_comb begin
        idx   = '0;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PTR_W'((int'(rr) + i) % N_REQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Busy wins over a timeout landing in the same cycle.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        unique case (state)
            IDLE: begin
                if (found && !bus.drv_busy) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                start = 1'b1;
                if (bus.drv_busy)             state_nxt = WAIT_DONE;
                else if (cnt == LAUNCH_LAST)  state_nxt = COMPLETE;
            end
            WAIT_DONE: begin
                if (!bus.drv_busy || cnt == XFER_LAST) state_nxt = COMPLETE;
            end
            COMPLETE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Completion status is registered on entry to COMPLETE so it is
    // visible for exactly the COMPLETE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            rr      <= '0;
            owner   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            abort_q <= 1'b0;
        end else begin
            done_q  <= '0;
            err_q   <= '0;
            abort_q <= 1'b0;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (state_nxt == LAUNCH) begin
                        owner   <= pick;
                        grant_q <= N_REQ'(1) << pick;
                        rw_q    <= bus.req_rw[pick];
                        addr_q  <= bus.req_addr[7*int'(pick) +: 7];
                        wdata_q <= bus.req_wdata[8*int'(pick) +: 8];
                    end
                end
                LAUNCH: begin
                    if (state_nxt == COMPLETE) begin
                        done_q <= grant_q;
                        err_q  <= grant_q;
                    end
                end
                WAIT_DONE: begin
                    if (state_nxt == COMPLETE) begin
                        done_q <= grant_q;
                        if (bus.drv_busy) begin
                            err_q   <= grant_q;
                            abort_q <= 1'b1;
                        end else if (rw_q) begin
                            rdata_q <= bus.drv_rdata;
                        end
                    end
                end
                COMPLETE: begin
                    grant_q <= '0;
                    rr      <= (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
                end
                default: begin
                    grant_q <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized self-checking bench for i2c_req_arbiter against a transaction-level model.
// Ports: none (top-level bench; drives the client and driver side of the interface).
module tb_i2c_req_arbiter;
    localparam int N  = 4;
    localparam int LT = 16;
    localparam int XT = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] pend = '0;

    i2c_req_arbiter_if #(.N_REQ(N)) bus ();

    i2c_req_arbiter #(
        .N_REQ(N),
        .LAUNCH_TMO(LT),
        .XFER_TMO(XT),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.req = pend;

    int vecs = 0;
    int errs = 0;
    int m_rr = 0;
    logic [7:0] m_rdata = '0;
    bit fid_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            if (errs <= 40) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_fields(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
        bus.req_rw[i]            = rw;
        bus.req_addr[7*i +: 7]   = a;
        bus.req_wdata[8*i +: 8]  = d;
    endtask

    task automatic newreq(input int i);
        set_fields(i, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom));
        pend[i] = 1'b1;
    endtask

    // Spec rule: first pending client scanning up from the pointer, wrapping.
    function automatic int pick_owner();
        for (int k = 0; k < N; k++) begin
            if (pend[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            chk("idle_grant", 32'(bus.grant), 0);
            chk("rdata_hold", 32'(bus.rdata), 32'(m_rdata));
        end
    endtask

    task automatic fiddle(input int own);
        int c;
        int j;
        if (!fid_en) return;
        c = $urandom_range(0, 7);
        j = $urandom_range(0, N - 1);
        if (c == 0) begin
            set_fields(own, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom));
        end else if (c == 1) begin
            pend[own] = 1'b0;
        end else if (c == 2 && j != own && !pend[j]) begin
            newreq(j);
        end
    endtask

    // One granted transaction; returns at the done cycle.
    // mode 0 normal, 1 launch timeout, 2 transfer timeout.
    task automatic xact(input int lat, input int mode, input int d1, input int d2,
                        input logic [7:0] rd, input bit rehold, output int own);
        logic [N-1:0] oh;
        logic         erw;
        logic [6:0]   eaddr;
        logic [7:0]   ewd;
        own   = pick_owner();
        oh    = '0;
        oh[own] = 1'b1;
        erw   = bus.req_rw[own];
        eaddr = bus.req_addr[7*own +: 7];
        ewd   = bus.req_wdata[8*own +: 8];
        for (int t = 1; t < lat; t++) begin
            tick();
            chk("gap_grant", 32'(bus.grant), 0);
            chk("gap_abort", 32'(bus.drv_abort), 0);
        end
        tick();
        chk("grant", 32'(bus.grant), 32'(oh));
        chk("drv_start", 32'(bus.drv_start), 1);
        chk("drv_rw", 32'(bus.drv_rw), 32'(erw));
        chk("drv_addr", 32'(bus.drv_addr), 32'(eaddr));
        chk("drv_wdata", 32'(bus.drv_wdata), 32'(ewd));
        bus.drv_rdata = rd;
        if (mode == 1) begin
            for (int k = 1; k < LT; k++) begin
                fiddle(own);
                tick();
                chk("start_hold", 32'(bus.drv_start), 1);
            end
            tick();
            chk("ltmo_start", 32'(bus.drv_start), 0);
            chk("ltmo_abort", 32'(bus.drv_abort), 0);
            chk("ltmo_done", 32'(bus.done), 32'(oh));
            chk("ltmo_err", 32'(bus.err), 32'(oh));
        end else begin
            for (int k = 1; k <= d1; k++) begin
                fiddle(own);
                tick();
                chk("start_hold", 32'(bus.drv_start), 1);
            end
            bus.drv_busy = 1'b1;
            tick();
            chk("start_drop", 32'(bus.drv_start), 0);
            chk("grant_hold", 32'(bus.grant), 32'(oh));
            if (mode == 0) begin
                for (int k = 1; k <= d2; k++) begin
                    fiddle(own);
                    tick();
                    chk("early_done", 32'(bus.done), 0);
                end
                bus.drv_busy = 1'b0;
                tick();
                chk("done", 32'(bus.done), 32'(oh));
                chk("err", 32'(bus.err), 0);
                chk("abort", 32'(bus.drv_abort), 0);
                if (erw) m_rdata = rd;
            end else begin
                for (int k = 1; k < XT; k++) begin
                    fiddle(own);
                    tick();
                    chk("early_abort", 32'(bus.drv_abort), 0);
                    chk("early_done", 32'(bus.done), 0);
                end
                tick();
                chk("xtmo_abort", 32'(bus.drv_abort), 1);
                chk("xtmo_done", 32'(bus.done), 32'(oh));
                chk("xtmo_err", 32'(bus.err), 32'(oh));
                bus.drv_busy = 1'b0;
            end
        end
        chk("rdata", 32'(bus.rdata), 32'(m_rdata));
        chk("drv_addr_stable", 32'(bus.drv_addr), 32'(eaddr));
        chk("drv_wdata_stable", 32'(bus.drv_wdata), 32'(ewd));
        chk("drv_rw_stable", 32'(bus.drv_rw), 32'(erw));
        m_rr = (own + 1) % N;
        pend[own] = rehold;
    endtask

    initial begin
        int own;
        int rr_exp [5];
        rr_exp = '{0, 1, 2, 3, 0};
        bus.req_rw    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.drv_rdata = '0;
        bus.drv_busy  = 1'b0;

        tick();
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_start", 32'(bus.drv_start), 0);
        chk("rst_abort", 32'(bus.drv_abort), 0);
        chk("rst_rdata", 32'(bus.rdata), 0);
        chk("rst_addr", 32'(bus.drv_addr), 0);
        rst_n = 1'b1;
        idle(2);

        // Round robin with all four clients holding req.
        for (int i = 0; i < N; i++) newreq(i);
        for (int i = 0; i < 5; i++) begin
            xact((i == 0) ? 1 : 2, 0, 1, 4, 8'($urandom), 1'b1, own);
            chk("rr_order", own, rr_exp[i]);
        end
        pend = '0;
        idle(2);

        // Single write from client 0.
        set_fields(0, 1'b0, 7'h50, 8'hA5);
        pend = 4'b0001;
        xact(1, 0, 3, 25, 8'h99, 1'b0, own);
        chk("t1_owner", own, 0);
        idle(1);

        // Read from client 2.
        set_fields(2, 1'b1, 7'h21, 8'h00);
        pend = 4'b0100;
        xact(1, 0, 2, 10, 8'h3C, 1'b0, own);
        chk("t2_rdata", 32'(bus.rdata), 32'h3C);
        idle(3);

        // Launch timeout on client 1 (read: rdata must not change).
        set_fields(1, 1'b1, 7'h11, 8'h22);
        pend = 4'b0010;
        xact(1, 1, 0, 0, 8'h77, 1'b0, own);
        chk("t4_owner", own, 1);
        idle(1);

        // Transfer timeout, then the queued request is still served.
        set_fields(3, 1'b1, 7'h33, 8'h44);
        set_fields(0, 1'b0, 7'h0A, 8'h0B);
        pend = 4'b1001;
        xact(1, 2, 1, 0, 8'h55, 1'b0, own);
        chk("t5_owner", own, 3);
        xact(2, 0, 2, 3, 8'h66, 1'b0, own);
        chk("t5_next", own, 0);
        idle(1);

        // Stray busy in idle blocks arbitration.
        bus.drv_busy = 1'b1;
        newreq(3);
        idle(5);
        bus.drv_busy = 1'b0;
        xact(1, 0, 1, 2, 8'($urandom), 1'b0, own);
        idle(1);

        // Randomized traffic.
        fid_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            int lat;
            int mode;
            if (pend == '0) begin
                idle($urandom_range(1, 3));
                newreq($urandom_range(0, N - 1));
                lat = 1;
            end else begin
                lat = 2;
            end
            mode = $urandom_range(0, 9);
            mode = (mode < 8) ? 0 : mode - 7;
            xact(lat, mode, $urandom_range(0, 4), $urandom_range(1, 20),
                 8'($urandom), 1'b0, own);
            for (int j = 0; j < N; j++) begin
                if (!pend[j] && $urandom_range(0, 2) == 0) newreq(j);
            end
        end
        fid_en = 1'b0;
        pend = '0;
        idle(2);

        // Reset during WAIT_DONE.
        set_fields(1, 1'b1, 7'h12, 8'h34);
        pend = 4'b0010;
        tick();
        chk("t6_grant", 32'(bus.grant), 32'h2);
        bus.drv_busy = 1'b1;
        set_fields(2, 1'b0, 7'h5A, 8'hC3);
        pend[2] = 1'b1;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_grant0", 32'(bus.grant), 0);
        chk("t6_done0", 32'(bus.done), 0);
        chk("t6_err0", 32'(bus.err), 0);
        chk("t6_start0", 32'(bus.drv_start), 0);
        chk("t6_abort0", 32'(bus.drv_abort), 0);
        chk("t6_rdata0", 32'(bus.rdata), 0);
        chk("t6_addr0", 32'(bus.drv_addr), 0);
        bus.drv_busy = 1'b0;
        pend = 4'b0100;
        tick();
        chk("t6_nodone", 32'(bus.done), 0);
        rst_n = 1'b1;
        m_rr = 0;
        m_rdata = '0;
        xact(1, 0, 2, 5, 8'h81, 1'b0, own);
        chk("t6_owner", own, 2);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
